// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: prescaled 64-bit machine timer plus edge-triggered external sources,
// prioritised into a held interrupt code for the CSR block.
module irq_timer_ctrl #(
  parameter int N_SRC      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_sel,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic [N_SRC-1:0] ext_irq,
  input  logic             irq_ack,
  output logic [3:0]       interrupt
);
  typedef enum logic [2:0] {IDLE, REQ_EXT, REQ_TMR, WAIT_EXT, WAIT_TMR} state_t;
  state_t                state, state_nx;
  logic [63:0]           mtime, mtimecmp;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [N_SRC-1:0]      ie, ip, sync1, sync2, sync3, rise, clr, claim_oh;
  logic [31:0]           claim_id, rd_val;
  logic                  wr, rd, tick, timer_pend, ext_pend;

  assign wr         = bus_sel & bus_we;
  assign rd         = bus_sel & ~bus_we;
  assign tick       = pcnt == '0;
  assign timer_pend = mtime >= mtimecmp;
  assign ext_pend   = |(ip & ie);
  assign rise       = sync2 & ~sync3;
  assign clr        = (wr && bus_addr == 3'd6 ? bus_wdata[N_SRC-1:0] : '0) |
                      (rd && bus_addr == 3'd7 ? claim_oh : '0);

  // Descending scan so the lowest-index pending source wins.
  always_comb begin
    claim_oh = '0;
    claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (ip[i] & ie[i]) begin
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
        claim_id    = 32'(i + 1);
      end
  end

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      3'd0:    rd_val = mtime[31:0];
      3'd1:    rd_val = mtime[63:32];
      3'd2:    rd_val = mtimecmp[31:0];
      3'd3:    rd_val = mtimecmp[63:32];
      3'd4:    rd_val[PRESCALE_W-1:0] = prescale;
      3'd5:    rd_val[N_SRC-1:0] = ie;
      3'd6:    rd_val[N_SRC-1:0] = ip;
      default: rd_val = claim_id;
    endcase
  end

  // WAIT_* states hold off re-trapping until software has cleared the source.
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:     state_nx = ext_pend ? REQ_EXT : timer_pend ? REQ_TMR : IDLE;
      REQ_EXT:  state_nx = irq_ack ? WAIT_EXT : ext_pend ? REQ_EXT : IDLE;
      REQ_TMR:  state_nx = irq_ack ? WAIT_TMR : ext_pend ? REQ_EXT : timer_pend ? REQ_TMR : IDLE;
      WAIT_EXT: state_nx = ext_pend ? WAIT_EXT : IDLE;
      WAIT_TMR: state_nx = timer_pend ? WAIT_TMR : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      prescale  <= '0;
      pcnt      <= '0;
      ie        <= '0;
      ip        <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sync3     <= '0;
      bus_rdata <= '0;
      state     <= IDLE;
      interrupt <= '0;
    end else begin
      sync1     <= ext_irq;
      sync2     <= sync1;
      sync3     <= sync2;
      ip        <= (ip & ~clr) | rise;
      pcnt      <= tick ? prescale : pcnt - 1'b1;
      mtime     <= wr && bus_addr == 3'd0 ? {mtime[63:32], bus_wdata} :
                   wr && bus_addr == 3'd1 ? {bus_wdata, mtime[31:0]} :
                   tick ? mtime + 64'd1 : mtime;
      if (wr && bus_addr == 3'd2) mtimecmp[31:0] <= bus_wdata;
      if (wr && bus_addr == 3'd3) mtimecmp[63:32] <= bus_wdata;
      if (wr && bus_addr == 3'd4) prescale <= bus_wdata[PRESCALE_W-1:0];
      if (wr && bus_addr == 3'd5) ie <= bus_wdata[N_SRC-1:0];
      if (rd) bus_rdata <= rd_val;
      state     <= state_nx;
      interrupt <= state_nx == REQ_EXT ? 4'd2 : state_nx == REQ_TMR ? 4'd1 : 4'd0;
    end
endmodule
